// File: rtl/snn_pkg.sv
// Shared SNN types and defaults for the neuron datapath.
`default_nettype none

package snn_pkg;

  localparam int VMEM_W   = 16;
  localparam int WEIGHT_W = 8;

  typedef logic signed [VMEM_W-1:0] vmem_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    REFRACT = 1'b1
  } lif_state_t;

  localparam int V_RESET_DEF = 0;
  localparam int V_MIN_DEF   = -16384;

endpackage

`default_nettype wire

// File: rtl/lif_leak_clamp.sv
// Combinational leak (v - v>>>shift) followed by a lower clamp at V_MIN.
`default_nettype none

module lif_leak_clamp
  import snn_pkg::*;
#(
  parameter int VMEM_W = snn_pkg::VMEM_W,
  parameter int V_MIN  = snn_pkg::V_MIN_DEF
) (
  input  logic signed [VMEM_W-1:0] v_in,
  input  logic        [3:0]        shift,
  output logic signed [VMEM_W-1:0] v_out
);

  localparam logic signed [VMEM_W-1:0] V_MIN_C = VMEM_W'(V_MIN);

  logic signed [VMEM_W-1:0] shifted;
  logic signed [VMEM_W-1:0] v_l;

  // A shift of zero means "no leak", not "subtract the whole value".
  always_comb begin
    shifted = v_in >>> shift;
    v_l     = (shift == 4'd0) ? v_in : (v_in - shifted);
    v_out   = (v_l < V_MIN_C) ? V_MIN_C : v_l;
  end

endmodule

`default_nettype wire

// File: rtl/lif_spike_gen.sv
// Leaky integrate-and-fire output stage: leak, threshold, refractory hold,
// one registered spike token per accepted timestep and a saturating fire count.
`default_nettype none

module lif_spike_gen
  import snn_pkg::*;
#(
  parameter int VMEM_W       = snn_pkg::VMEM_W,
  parameter int V_RESET      = snn_pkg::V_RESET_DEF,
  parameter int V_MIN        = snn_pkg::V_MIN_DEF,
  parameter int REFRAC_STEPS = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_valid,
  output logic                     step_ready,
  input  logic signed [VMEM_W-1:0] vmem_in,
  input  logic signed [VMEM_W-1:0] threshold,
  input  logic        [3:0]        leak_shift,
  output logic                     spike_valid,
  input  logic                     spike_ready,
  output logic                     spike_out,
  output logic signed [VMEM_W-1:0] vmem_out,
  output logic        [CNT_W-1:0]  spike_count,
  input  logic                     clear_count
);

  localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [RC_W-1:0]          REFRAC_C  = RC_W'(REFRAC_STEPS);
  localparam logic signed [VMEM_W-1:0] V_RESET_C = VMEM_W'(V_RESET);

  lif_state_t               state_q, state_d;
  logic [RC_W-1:0]          rcnt_q, rcnt_d;
  logic signed [VMEM_W-1:0] v_leaked;
  logic signed [VMEM_W-1:0] vmem_d;
  logic                     spike_d;
  logic                     accept;
  logic                     fire;

  assign step_ready = !spike_valid || spike_ready;
  assign accept     = step_valid && step_ready;

  lif_leak_clamp #(
    .VMEM_W (VMEM_W),
    .V_MIN  (V_MIN)
  ) u_leak (
    .v_in  (vmem_in),
    .shift (leak_shift),
    .v_out (v_leaked)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    vmem_d  = vmem_out;
    spike_d = spike_out;
    fire    = 1'b0;
    if (accept) begin
      case (state_q)
        RUN: begin
          if (v_leaked >= threshold) begin
            fire    = 1'b1;
            spike_d = 1'b1;
            vmem_d  = V_RESET_C;
            if (REFRAC_STEPS != 0) begin
              state_d = REFRACT;
              rcnt_d  = REFRAC_C;
            end
          end else begin
            spike_d = 1'b0;
            vmem_d  = v_leaked;
          end
        end
        REFRACT: begin
          spike_d = 1'b0;
          vmem_d  = V_RESET_C;
          rcnt_d  = rcnt_q - RC_W'(1);
          if (rcnt_q == RC_W'(1)) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Token registers: loaded on acceptance, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_valid <= 1'b0;
      spike_out   <= 1'b0;
      vmem_out    <= V_RESET_C;
    end else if (accept) begin
      spike_valid <= 1'b1;
      spike_out   <= spike_d;
      vmem_out    <= vmem_d;
    end else if (spike_ready) begin
      spike_valid <= 1'b0;
    end
  end

  // Clear takes priority, so a fire in the same cycle lands as a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count <= '0;
    end else if (clear_count) begin
      spike_count <= fire ? CNT_W'(1) : '0;
    end else if (fire && !(&spike_count)) begin
      spike_count <= spike_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
